// File: rtl/pipelined_multiplier.sv
// ============================================================================
// Module   : pipelined_multiplier
// Purpose  : STAGES-deep signed/unsigned integer multiplier with ROB tag,
//            valid/ready backpressure and flush kill. Optional performance
//            counters are enabled by defining MUL_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_multiplier #(
  parameter int DATA_W = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              kill,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              src1_signed,
  input  logic              src2_signed,
  input  logic              sel_lohi,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [TAG_W-1:0]  out_tag
`ifdef MUL_PERF_CNT_EN
  ,
  output logic [31:0]       perf_issued,
  output logic [31:0]       perf_stall
`endif
);

  localparam int PROD_W = 2 * DATA_W;

  logic              advance;
  logic              accept;
  logic [PROD_W-1:0] src1_ext;
  logic [PROD_W-1:0] src2_ext;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] last_prod;
  logic              last_sel;
  logic [TAG_W-1:0]  last_tag;
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  logic [DATA_W-1:0] result_q;
  logic [TAG_W-1:0]  out_tag_q;

  assign out_valid = vld_q[STAGES-1];
  assign result    = result_q;
  assign out_tag   = out_tag_q;
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance && !kill && !reset;
  assign accept    = in_valid && in_ready;

  // Extending both operands to the full product width lets a plain modular
  // multiply yield the exact low 2*DATA_W bits of the signed product.
  assign src1_ext = {{DATA_W{src1_signed & src1[DATA_W-1]}}, src1};
  assign src2_ext = {{DATA_W{src2_signed & src2[DATA_W-1]}}, src2};
  assign prod     = src1_ext * src2_ext;

  always_comb begin
    vld_d = vld_q;
    if (advance) begin
      vld_d[0] = accept;
      for (int i = 1; i < STAGES; i++) begin
        vld_d[i] = vld_q[i-1];
      end
    end
    if (reset || kill) begin
      vld_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    vld_q <= vld_d;
  end

  generate
    if (STAGES > 1) begin : g_pipe
      logic [PROD_W-1:0] prod_q [STAGES-1];
      logic [TAG_W-1:0]  tag_q  [STAGES-1];
      logic [STAGES-2:0] sel_q;

      // Intermediate slots carry the full product; stalls freeze every slot.
      always_ff @(posedge clk) begin
        if (advance) begin
          prod_q[0] <= prod;
          tag_q[0]  <= in_tag;
          sel_q[0]  <= sel_lohi;
          for (int i = 1; i < STAGES - 1; i++) begin
            prod_q[i] <= prod_q[i-1];
            tag_q[i]  <= tag_q[i-1];
            sel_q[i]  <= sel_q[i-1];
          end
        end
      end

      assign last_prod = prod_q[STAGES-2];
      assign last_tag  = tag_q[STAGES-2];
      assign last_sel  = sel_q[STAGES-2];
    end else begin : g_direct
      assign last_prod = prod;
      assign last_tag  = in_tag;
      assign last_sel  = sel_lohi;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q  <= '0;
      out_tag_q <= '0;
    end else if (advance) begin
      result_q  <= last_sel ? last_prod[PROD_W-1:DATA_W] : last_prod[DATA_W-1:0];
      out_tag_q <= last_tag;
    end
  end

`ifdef MUL_PERF_CNT_EN
  logic [31:0] perf_issued_q;
  logic [31:0] perf_stall_q;

  // Counters ignore kill so flushed work still shows up as issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (accept) begin
        perf_issued_q <= perf_issued_q + 32'd1;
      end
      if (out_valid && !out_ready) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipelined_multiplier.sv
// ============================================================================
// Module   : tb_pipelined_multiplier
// Purpose  : Scoreboard bench for pipelined_multiplier (DATA_W=32, STAGES=3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_multiplier;

  localparam int DATA_W = 32;
  localparam int STAGES = 3;
  localparam int TAG_W  = 6;
  localparam int NVEC   = 14;

  logic              clk = 1'b0;
  logic              reset;
  logic              kill;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic              src1_signed;
  logic              src2_signed;
  logic              sel_lohi;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic [TAG_W-1:0]  out_tag;
`ifdef MUL_PERF_CNT_EN
  logic [31:0]       perf_issued;
  logic [31:0]       perf_stall;
`endif

  pipelined_multiplier #(
    .DATA_W(DATA_W),
    .STAGES(STAGES),
    .TAG_W (TAG_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .kill       (kill),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .src1       (src1),
    .src2       (src2),
    .src1_signed(src1_signed),
    .src2_signed(src2_signed),
    .sel_lohi   (sel_lohi),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .out_tag    (out_tag)
`ifdef MUL_PERF_CNT_EN
    ,
    .perf_issued(perf_issued),
    .perf_stall (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Directed vectors: operands, signedness, half select, hand-computed result.
  logic [31:0] va  [NVEC] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'h00000000,
                              32'h80000000, 32'h12345678, 32'hFFFFFFFF, 32'h00010000,
                              32'hFFFFFFFE, 32'h00000003};
  logic [31:0] vb  [NVEC] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'h80000000, 32'h80000000, 32'h80000000, 32'hFFFFFFFF,
                              32'h7FFFFFFF, 32'h00000002, 32'h00000007, 32'h00010000,
                              32'h00000003, 32'hFFFFFFFE};
  logic        vs1 [NVEC] = '{0, 0, 1, 1, 1, 1, 0, 1, 1, 0, 1, 0, 1, 0};
  logic        vs2 [NVEC] = '{0, 0, 1, 0, 1, 1, 1, 1, 1, 0, 1, 0, 0, 1};
  logic        vhi [NVEC] = '{1, 0, 1, 1, 1, 0, 1, 1, 1, 0, 0, 1, 1, 0};
  logic [31:0] vex [NVEC] = '{32'hFFFFFFFE, 32'h00000001, 32'h00000000, 32'hFFFFFFFF,
                              32'h40000000, 32'h00000000, 32'h80000000, 32'h00000000,
                              32'hC0000000, 32'h2468ACF0, 32'hFFFFFFF9, 32'h00000001,
                              32'hFFFFFFFF, 32'hFFFFFFFA};

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] res;
    int                due;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives vector idx; waits (bounded) for in_ready; optionally records the expectation.
  task automatic issue(input int idx, input logic [TAG_W-1:0] tag, input bit track, input bit lat);
    int waited = 0;
    in_valid    = 1'b1;
    src1        = va[idx];
    src2        = vb[idx];
    src1_signed = vs1[idx];
    src2_signed = vs2[idx];
    sel_lohi    = vhi[idx];
    in_tag      = tag;
    @(negedge clk);
    while (in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      chk("issue_timeout", 32'(in_ready), 32'd1);
    end else if (track) begin
      sb.push_back('{tag: tag, res: vex[idx], due: lat ? cyc + STAGES : -1});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && kill === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_output_tag", 32'(out_tag), 32'hFFFFFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("out_tag", 32'(out_tag), 32'(e.tag));
        if (e.due >= 0) chk("latency_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    reset = 1'b1; kill = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    src1 = '0; src2 = '0; src1_signed = 1'b0; src2_signed = 1'b0;
    sel_lohi = 1'b0; in_tag = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_out_tag", 32'(out_tag), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Single requests, first one accepted in cycle 10.
    while (cyc != 10) begin
      @(posedge clk); #1;
    end
    issue(0, 6'd5, 1, 1);
    wait_empty();
    for (int k = 1; k < 6; k++) begin
      issue(k, 6'(k + 5), 1, 1);
      wait_empty();
    end

    // Back-to-back stream, tags 0..7.
    for (int k = 0; k < 8; k++) issue(k + 6, 6'(k), 1, 1);
    wait_empty();

    // Backpressure: four requests, then a five-cycle consumer stall.
    for (int k = 0; k < 4; k++) issue(k, 6'(20 + k), 1, 0);
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      if (sb.size() != 0) begin
        chk("stall_result_held", result, sb[0].res);
        chk("stall_tag_held", 32'(out_tag), 32'(sb[0].tag));
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_empty();
`ifdef MUL_PERF_CNT_EN
    chk("perf_stall", perf_stall, 32'd5);
`endif

    // Kill with three in flight and a simultaneous request.
    for (int k = 0; k < 3; k++) issue(k + 8, 6'(40 + k), 0, 0);
    kill = 1'b1; in_valid = 1'b1; in_tag = 6'd49;
    @(negedge clk);
    chk("kill_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    kill = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_kill_out_valid", 32'(out_valid), 32'd0);
    chk("post_kill_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    issue(3, 6'd50, 1, 1);
    wait_empty();
    idle(4);

    // Reset with two operations pending.
    issue(4, 6'd60, 0, 0);
    issue(8, 6'd61, 0, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);
`ifdef MUL_PERF_CNT_EN
    chk("perf_issued_after_reset", perf_issued, 32'd0);
`endif
    for (int s = 0; s < 6; s++) begin
      chk("post_reset_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    issue(12, 6'd62, 1, 1);
    wait_empty();
    idle(3);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "bench timeout");
  end

endmodule

`default_nettype wire
